// File: rtl/rv32_multicycle_controller.sv
// RV32I multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// with req/ready memory handshakes, illegal-op and timeout traps.
module rv32_multicycle_controller #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_W       = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_instruction,
  input  logic            i_imem_ready,
  input  logic            i_dmem_ready,
  input  logic            i_BrEq,
  input  logic            i_BrLt,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            MemRW,
  output logic            PCWrite,
  output logic            PCSel,
  output logic [2:0]      ImmSel,
  output logic            BrUn,
  output logic            ASel,
  output logic            BSel,
  output logic [3:0]      ALUSel,
  output logic            RegWEn,
  output logic [1:0]      WBSel,
  output logic            illegal,
  output logic            fault,
  output logic [2:0]      state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [TO_CNT_W-1:0] TO_LAST =
    TO_CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  logic [31:0]         ir;
  logic                armed;
  logic [TO_CNT_W-1:0] to_cnt;
  logic [2:0]          nxt;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  logic op_r, op_i, op_ld, op_st, op_br;
  logic op_jal, op_jalr, op_lui, op_auipc;
  assign op_r     = opc == 7'b0110011;
  assign op_i     = opc == 7'b0010011;
  assign op_ld    = opc == 7'b0000011;
  assign op_st    = opc == 7'b0100011;
  assign op_br    = opc == 7'b1100011;
  assign op_jal   = opc == 7'b1101111;
  assign op_jalr  = opc == 7'b1100111;
  assign op_lui   = opc == 7'b0110111;
  assign op_auipc = opc == 7'b0010111;

  function automatic logic [3:0] alu_of(
    input logic [2:0] f,
    input logic       alt
  );
    case (f)
      3'b000:  alu_of = alt ? 4'd1 : 4'd0;
      3'b001:  alu_of = 4'd2;
      3'b010:  alu_of = 4'd3;
      3'b011:  alu_of = 4'd4;
      3'b100:  alu_of = 4'd5;
      3'b101:  alu_of = alt ? 4'd7 : 4'd6;
      3'b110:  alu_of = 4'd8;
      default: alu_of = 4'd9;
    endcase
  endfunction

  logic       d_legal, d_asel, d_bsel, d_brun, d_memrw;
  logic [2:0] d_imm;
  logic [3:0] d_alu;
  logic [1:0] d_wb;

  always_comb begin
    d_legal = 1'b0;
    d_asel  = 1'b0;
    d_bsel  = 1'b0;
    d_brun  = 1'b0;
    d_memrw = 1'b0;
    d_imm   = 3'd0;
    d_alu   = 4'd0;
    d_wb    = 2'd0;
    unique case (1'b1)
      op_r: begin
        d_wb    = 2'd1;
        d_alu   = alu_of(f3, ir[30]);
        d_legal = (f7 == 7'b0) ||
                  (f7 == 7'b0100000 &&
                   (f3 == 3'b000 || f3 == 3'b101));
      end
      op_i: begin
        d_bsel = 1'b1;
        d_wb   = 2'd1;
        // bit30 only selects SRAI; ADDI immediates may set it freely
        d_alu  = alu_of(f3, f3 == 3'b101 && ir[30]);
        if (f3 == 3'b001)
          d_legal = f7 == 7'b0;
        else if (f3 == 3'b101)
          d_legal = f7 == 7'b0 || f7 == 7'b0100000;
        else
          d_legal = 1'b1;
      end
      op_ld: begin
        d_bsel  = 1'b1;
        d_legal = f3 != 3'b011 && f3 != 3'b110 &&
                  f3 != 3'b111;
      end
      op_st: begin
        d_imm   = 3'd1;
        d_bsel  = 1'b1;
        d_memrw = 1'b1;
        d_legal = !f3[2] && f3 != 3'b011;
      end
      op_br: begin
        d_imm   = 3'd2;
        d_asel  = 1'b1;
        d_bsel  = 1'b1;
        d_brun  = f3[2] & f3[1];
        d_legal = f3 != 3'b010 && f3 != 3'b011;
      end
      op_jal: begin
        d_imm   = 3'd4;
        d_asel  = 1'b1;
        d_bsel  = 1'b1;
        d_wb    = 2'd2;
        d_legal = 1'b1;
      end
      op_jalr: begin
        d_bsel  = 1'b1;
        d_wb    = 2'd2;
        d_legal = f3 == 3'b000;
      end
      op_lui: begin
        d_imm   = 3'd3;
        d_bsel  = 1'b1;
        d_alu   = 4'd10;
        d_wb    = 2'd1;
        d_legal = 1'b1;
      end
      op_auipc: begin
        d_imm   = 3'd3;
        d_asel  = 1'b1;
        d_bsel  = 1'b1;
        d_wb    = 2'd1;
        d_legal = 1'b1;
      end
      default: ;
    endcase
  end

  logic taken, waiting, to_hit;
  assign taken = f3[2] ? (i_BrLt ^ f3[0]) : (i_BrEq ^ f3[0]);

  // armed keeps imem_req low until the first edge after reset release
  assign imem_req = state == S_FETCH && armed;
  assign dmem_req = state == S_MEM;
  assign RegWEn   = state == S_WB;
  assign PCWrite  = (state == S_EXEC && op_br) ||
                    (state == S_MEM && op_st && i_dmem_ready) ||
                    (state == S_WB);
  assign PCSel    = (state == S_EXEC && op_br && taken) ||
                    (state == S_WB && (op_jal || op_jalr));

  assign waiting = (imem_req && !i_imem_ready) ||
                   (dmem_req && !i_dmem_ready);
  assign to_hit  = TIMEOUT_CYCLES != 0 && waiting &&
                   to_cnt == TO_LAST;

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:
        if (imem_req && i_imem_ready) nxt = S_DECODE;
        else if (to_hit)              nxt = S_TRAP;
      S_DECODE: nxt = d_legal ? S_EXEC : S_TRAP;
      S_EXEC:
        if (op_br)               nxt = S_FETCH;
        else if (op_ld || op_st) nxt = S_MEM;
        else                     nxt = S_WB;
      S_MEM:
        if (i_dmem_ready) nxt = op_ld ? S_WB : S_FETCH;
        else if (to_hit)  nxt = S_TRAP;
      S_WB:    nxt = S_FETCH;
      default: nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_FETCH;
      armed   <= 1'b0;
      ir      <= '0;
      to_cnt  <= '0;
      illegal <= 1'b0;
      fault   <= 1'b0;
      ImmSel  <= '0;
      ASel    <= 1'b0;
      BSel    <= 1'b0;
      ALUSel  <= '0;
      WBSel   <= '0;
      BrUn    <= 1'b0;
      MemRW   <= 1'b0;
    end else begin
      state  <= nxt;
      armed  <= 1'b1;
      to_cnt <= (waiting && !to_hit) ? to_cnt + 1'b1 : '0;
      if (imem_req && i_imem_ready)
        ir <= i_instruction[31:0];
      if (state == S_DECODE && !d_legal)
        illegal <= 1'b1;
      if (to_hit)
        fault <= 1'b1;
      if (state == S_DECODE && d_legal) begin
        ImmSel <= d_imm;
        ASel   <= d_asel;
        BSel   <= d_bsel;
        ALUSel <= d_alu;
        WBSel  <= d_wb;
        BrUn   <= d_brun;
        MemRW  <= d_memrw;
      end else if (nxt == S_FETCH) begin
        ImmSel <= '0;
        ASel   <= 1'b0;
        BSel   <= 1'b0;
        ALUSel <= '0;
        WBSel  <= '0;
        BrUn   <= 1'b0;
        MemRW  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_multicycle_controller.sv
// Bench for rv32_multicycle_controller: vector table with a
// scoreboard queue plus hand-written trap/reset sequences.
module tb_rv32_multicycle_controller;

  logic        clk;
  logic        rst;
  logic [31:0] i_instruction;
  logic        i_imem_ready, i_dmem_ready, i_BrEq, i_BrLt;
  logic        imem_req, dmem_req, MemRW, PCWrite, PCSel;
  logic [2:0]  ImmSel;
  logic        BrUn, ASel, BSel;
  logic [3:0]  ALUSel;
  logic        RegWEn;
  logic [1:0]  WBSel;
  logic        illegal, fault;
  logic [2:0]  state;

  rv32_multicycle_controller dut (
    .i_clk(clk), .i_rst(rst),
    .i_instruction(i_instruction),
    .i_imem_ready(i_imem_ready),
    .i_dmem_ready(i_dmem_ready),
    .i_BrEq(i_BrEq), .i_BrLt(i_BrLt),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .MemRW(MemRW), .PCWrite(PCWrite), .PCSel(PCSel),
    .ImmSel(ImmSel), .BrUn(BrUn), .ASel(ASel),
    .BSel(BSel), .ALUSel(ALUSel), .RegWEn(RegWEn),
    .WBSel(WBSel), .illegal(illegal), .fault(fault),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] ctrl;
  logic [22:0] outs;
  assign ctrl = {ImmSel, ASel, BSel, ALUSel, WBSel, BrUn, MemRW};
  assign outs = {imem_req, dmem_req, MemRW, PCWrite, PCSel,
                 ImmSel, BrUn, ASel, BSel, ALUSel, RegWEn,
                 WBSel, illegal, fault, state};

  typedef struct packed {
    logic [31:0] ins;
    int          iw;
    int          dw;
    logic        beq;
    logic        blt;
    int          lat;
    logic [7:0]  mask;
    logic        pcsel;
    logic [2:0]  imm;
    logic        asel;
    logic        bsel;
    logic [3:0]  alu;
    logic [1:0]  wb;
    logic        brun;
    logic        memrw;
    int          rwe;
  } vec_t;

  typedef struct packed {
    int          n;
    int          pcw;
    int          rwe;
    logic [7:0]  mask;
    logic        pcsel;
    logic [12:0] ctrl;
    logic [12:0] fetch_ctrl;
    logic        trapped;
    logic        done;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input int iw,
                           input int dw, input logic beq,
                           input logic blt, output obs_t o);
    int   iwc, dwc;
    logic left;
    o = '0;
    iwc = 0;
    dwc = 0;
    left = 1'b0;
    i_BrEq = beq;
    i_BrLt = blt;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      i_imem_ready = 1'b0;
      i_dmem_ready = 1'b0;
      if (state == 3'd7) begin
        o.trapped = 1'b1;
        o.done = 1'b1;
        break;
      end
      if (left && state == 3'd0) begin
        o.done = 1'b1;
        o.fetch_ctrl = ctrl;
        break;
      end
      if (state != 3'd0) left = 1'b1;
      if (left || imem_req) begin
        if (state == 3'd0) begin
          if (iwc == iw) begin
            i_imem_ready = 1'b1;
            i_instruction = ins;
          end else iwc++;
        end
        if (state == 3'd3) begin
          if (dwc == dw) i_dmem_ready = 1'b1;
          else dwc++;
        end
        #1;
        o.n = o.n + 1;
        o.mask[state] = 1'b1;
        if (PCWrite) begin
          o.pcw = o.pcw + 1;
          o.pcsel = PCSel;
        end
        if (RegWEn) o.rwe = o.rwe + 1;
        if (state == 3'd2) o.ctrl = ctrl;
      end
    end
    i_imem_ready = 1'b0;
    i_dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vt[20];
  vec_t sb[$];
  vec_t e;
  obs_t o;
  int   side;

  initial begin
    rst = 1'b1;
    i_instruction = '0;
    i_imem_ready = 1'b0;
    i_dmem_ready = 1'b0;
    i_BrEq = 1'b0;
    i_BrLt = 1'b0;

    // ins iw dw beq blt lat mask pcsel imm a b alu wb brun memrw rwe
    vt[0]  = '{32'h00208033,0,0,0,0,4,8'h17,0,0,0,0,0,1,0,0,1};
    vt[1]  = '{32'h40208033,0,0,0,0,4,8'h17,0,0,0,0,1,1,0,0,1};
    vt[2]  = '{32'h4020D033,0,0,0,0,4,8'h17,0,0,0,0,7,1,0,0,1};
    vt[3]  = '{32'h40008093,0,0,0,0,4,8'h17,0,0,0,1,0,1,0,0,1};
    vt[4]  = '{32'h4010D093,0,0,0,0,4,8'h17,0,0,0,1,7,1,0,0,1};
    vt[5]  = '{32'h0010B093,0,0,0,0,4,8'h17,0,0,0,1,4,1,0,0,1};
    vt[6]  = '{32'h123450B7,0,0,0,0,4,8'h17,0,3,0,1,10,1,0,0,1};
    vt[7]  = '{32'h00001097,0,0,0,0,4,8'h17,0,3,1,1,0,1,0,0,1};
    vt[8]  = '{32'h008000EF,0,0,0,0,4,8'h17,1,4,1,1,0,2,0,0,1};
    vt[9]  = '{32'h000080E7,0,0,0,0,4,8'h17,1,0,0,1,0,2,0,0,1};
    vt[10] = '{32'h0000A083,0,3,0,0,8,8'h1F,0,0,0,1,0,0,0,0,1};
    vt[11] = '{32'h0020A023,0,0,0,0,4,8'h0F,0,1,0,1,0,0,0,1,0};
    vt[12] = '{32'h00208463,0,0,1,0,3,8'h07,1,2,1,1,0,0,0,0,0};
    vt[13] = '{32'h00208463,0,0,0,0,3,8'h07,0,2,1,1,0,0,0,0,0};
    vt[14] = '{32'h0020E463,0,0,0,1,3,8'h07,1,2,1,1,0,0,1,0,0};
    vt[15] = '{32'h0020D463,0,0,0,1,3,8'h07,0,2,1,1,0,0,0,0,0};
    vt[16] = '{32'h00208033,2,0,0,0,6,8'h17,0,0,0,0,0,1,0,0,1};
    vt[17] = '{32'h0020A023,0,1,0,0,5,8'h0F,0,1,0,1,0,0,0,1,0};
    vt[18] = '{32'h00209463,0,0,0,0,3,8'h07,1,2,1,1,0,0,0,0,0};
    vt[19] = '{32'h00209033,0,0,0,0,4,8'h17,0,0,0,0,2,1,0,0,1};

    repeat (2) @(negedge clk);
    #1 chk("reset_outs", 32'(outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("req_before_edge", 32'(imem_req), 32'd0);
    @(negedge clk);
    #1 chk("req_after_release", 32'(imem_req), 32'd1);

    foreach (vt[i]) begin
      sb.push_back(vt[i]);
      run_instr(vt[i].ins, vt[i].iw, vt[i].dw,
                vt[i].beq, vt[i].blt, o);
      e = sb.pop_front();
      chk($sformatf("v%0d_done", i), 32'(o.done), 32'd1);
      chk($sformatf("v%0d_lat", i), 32'(o.n), 32'(e.lat));
      chk($sformatf("v%0d_states", i), 32'(o.mask),
          32'(e.mask));
      chk($sformatf("v%0d_pcwrite", i), 32'(o.pcw), 32'd1);
      chk($sformatf("v%0d_pcsel", i), 32'(o.pcsel),
          32'(e.pcsel));
      chk($sformatf("v%0d_regwen", i), 32'(o.rwe), 32'(e.rwe));
      chk($sformatf("v%0d_ctrl", i), 32'(o.ctrl),
          32'({e.imm, e.asel, e.bsel, e.alu, e.wb,
               e.brun, e.memrw}));
      chk($sformatf("v%0d_fetch_ctrl", i), 32'(o.fetch_ctrl),
          32'd0);
    end

    // illegal opcode traps in DECODE without any strobe
    do_reset();
    run_instr(32'h0000007F, 0, 0, 0, 0, o);
    chk("ill_trapped", 32'(o.trapped), 32'd1);
    chk("ill_lat", 32'(o.n), 32'd2);
    chk("ill_strobes", 32'(o.pcw + o.rwe), 32'd0);
    side = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 side += int'(PCWrite) + int'(RegWEn) + int'(imem_req);
    end
    chk("ill_trap_quiet", 32'(side), 32'd0);
    chk("ill_flags", 32'({illegal, fault, state}), 32'b1_0_111);

    do_reset();
    #1 chk("reset_clears_flags", 32'({illegal, fault, state}),
           32'd0);

    // fetch timeout: 16 unacknowledged request cycles
    run_instr(32'h00208033, 1000, 0, 0, 0, o);
    chk("to_trapped", 32'(o.trapped), 32'd1);
    chk("to_cycles", 32'(o.n), 32'd16);
    repeat (5) @(negedge clk);
    #1 chk("to_flags", 32'({imem_req, illegal, fault, state}),
           32'b0_0_1_111);

    // ready on the limit cycle wins
    do_reset();
    run_instr(32'h00208033, 15, 0, 0, 0, o);
    chk("edge_trapped", 32'(o.trapped), 32'd0);
    chk("edge_lat", 32'(o.n), 32'd19);
    chk("edge_fault", 32'(fault), 32'd0);
    chk("edge_regwen", 32'(o.rwe), 32'd1);

    // data-side timeout during a store
    run_instr(32'h0020A023, 0, 1000, 0, 0, o);
    chk("dto_trapped", 32'(o.trapped), 32'd1);
    chk("dto_cycles", 32'(o.n), 32'd19);
    chk("dto_pcwrite", 32'(o.pcw), 32'd0);
    #1 chk("dto_flags", 32'({dmem_req, fault, state}),
           32'b0_1_111);

    // async reset while a store waits in MEM
    do_reset();
    for (int c = 0; c < 20 && !(state == 3'd0 && imem_req); c++)
      @(negedge clk);
    i_instruction = 32'h0020A023;
    i_imem_ready = 1'b1;
    @(negedge clk);
    i_imem_ready = 1'b0;
    for (int c = 0; c < 10 && state != 3'd3; c++)
      @(negedge clk);
    chk("mid_mem_reached", 32'(state), 32'd3);
    #2 rst = 1'b1;
    #1 chk("mid_mem_outs", 32'(outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(32'h00208033, 0, 0, 0, 0, o);
    chk("refetch_lat", 32'(o.n), 32'd4);
    chk("refetch_ctrl", 32'(o.ctrl), 32'({3'd0, 1'b0, 1'b0,
        4'd0, 2'd1, 1'b0, 1'b0}));
    chk("refetch_strobes", 32'({o.pcw[3:0], o.rwe[3:0]}),
        32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
